// File: rtl/mem_burst_arbiter.sv
// Round-robin arbiter that hands the single DDR burst engine to one of NUM_PORTS requesters per burst.
// Optional watchdog output arb_timeout is built when ARB_TIMEOUT_EN is defined.
module mem_burst_arbiter #(
    parameter int NUM_PORTS      = 2,
    parameter int MEM_DATA_BITS  = 64,
    parameter int ADDR_BITS      = 24,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                               mem_clk,
    input  logic                               rst_n,
    input  logic [NUM_PORTS-1:0]               req_rd_req,
    input  logic [NUM_PORTS-1:0]               req_wr_req,
    input  logic [NUM_PORTS*10-1:0]            req_rd_len,
    input  logic [NUM_PORTS*10-1:0]            req_wr_len,
    input  logic [NUM_PORTS*ADDR_BITS-1:0]     req_rd_addr,
    input  logic [NUM_PORTS*ADDR_BITS-1:0]     req_wr_addr,
    input  logic [NUM_PORTS*MEM_DATA_BITS-1:0] req_wr_data,
    output logic [NUM_PORTS-1:0]               req_wr_data_req,
    output logic [MEM_DATA_BITS-1:0]           req_rd_data,
    output logic [NUM_PORTS-1:0]               req_rd_data_valid,
    output logic [NUM_PORTS-1:0]               req_rd_finish,
    output logic [NUM_PORTS-1:0]               req_wr_finish,
    output logic                               rd_burst_req,
    output logic                               wr_burst_req,
    output logic [9:0]                         rd_burst_len,
    output logic [9:0]                         wr_burst_len,
    output logic [ADDR_BITS-1:0]               rd_burst_addr,
    output logic [ADDR_BITS-1:0]               wr_burst_addr,
    output logic [MEM_DATA_BITS-1:0]          wr_burst_data,
    input  logic                               wr_burst_data_req,
    input  logic                               rd_burst_data_valid,
    input  logic                               rd_burst_finish,
    input  logic                               wr_burst_finish,
    input  logic [MEM_DATA_BITS-1:0]           rd_burst_data,
    output logic [$clog2(NUM_PORTS)-1:0]       grant_id,
    output logic                               busy
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                               arb_timeout
`endif
);

    localparam int GW       = $clog2(NUM_PORTS);
    localparam int SW       = GW + 1;
    localparam int LEN_BITS = 10;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_WAIT = 2'd2, ST_COOL = 2'd3} state_t;

    if (NUM_PORTS < 2 || NUM_PORTS > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("mem_burst_arbiter: parameter out of range");
    end

    state_t          r_state;
    logic [GW-1:0]   r_rr_ptr;
    logic [GW-1:0]   r_grant;
    logic            r_op_rd;
    logic [NUM_PORTS-1:0] w_pending;
    logic            w_any;
    logic [GW-1:0]   w_sel;
    logic [GW-1:0]   w_next_ptr;
    logic [SW-1:0]   w_sum;
    logic [SW-1:0]   w_idx;
    logic            w_active;

    assign w_pending  = req_rd_req | req_wr_req;
    assign w_next_ptr = (w_sel == GW'(NUM_PORTS - 1)) ? '0 : w_sel + 1'b1;
    assign w_active   = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
    assign busy       = (r_state != ST_IDLE);
    assign grant_id   = r_grant;
    assign req_rd_data = rd_burst_data;

    // First pending port at or after rr_ptr, wrapping past the last port.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_sum = '0;
        w_idx = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_sum = {1'b0, r_rr_ptr} + SW'(k);
            w_idx = (w_sum >= SW'(NUM_PORTS)) ? w_sum - SW'(NUM_PORTS) : w_sum;
            if (!w_any && w_pending[w_idx[GW-1:0]]) begin
                w_any = 1'b1;
                w_sel = w_idx[GW-1:0];
            end else begin
                w_any = w_any;
            end
        end
    end

    // Burst FSM: grant, one-cycle engine command, wait for finish, one cool-down cycle.
    always_ff @(posedge mem_clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_rr_ptr      <= '0;
            r_grant       <= '0;
            r_op_rd       <= 1'b0;
            rd_burst_req  <= 1'b0;
            wr_burst_req  <= 1'b0;
            rd_burst_len  <= 10'd0;
            wr_burst_len  <= 10'd0;
            rd_burst_addr <= '0;
            wr_burst_addr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant  <= w_sel;
                        r_rr_ptr <= w_next_ptr;
                        r_op_rd  <= req_rd_req[w_sel];
                        r_state  <= ST_ISSUE;
                        // Read wins when a port raises both requests together.
                        if (req_rd_req[w_sel]) begin
                            rd_burst_req  <= 1'b1;
                            rd_burst_len  <= req_rd_len[w_sel*LEN_BITS +: LEN_BITS];
                            rd_burst_addr <= req_rd_addr[w_sel*ADDR_BITS +: ADDR_BITS];
                            wr_burst_req  <= 1'b0;
                            wr_burst_len  <= 10'd0;
                            wr_burst_addr <= '0;
                        end else begin
                            wr_burst_req  <= 1'b1;
                            wr_burst_len  <= req_wr_len[w_sel*LEN_BITS +: LEN_BITS];
                            wr_burst_addr <= req_wr_addr[w_sel*ADDR_BITS +: ADDR_BITS];
                            rd_burst_req  <= 1'b0;
                            rd_burst_len  <= 10'd0;
                            rd_burst_addr <= '0;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    rd_burst_req <= 1'b0;
                    wr_burst_req <= 1'b0;
                    r_state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if ((r_op_rd && rd_burst_finish) || (!r_op_rd && wr_burst_finish)) begin
                        r_state <= ST_COOL;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_COOL: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Owner-only routing of engine strobes, write data and finish pulses.
    always_comb begin
        req_wr_data_req   = '0;
        req_rd_data_valid = '0;
        req_rd_finish     = '0;
        req_wr_finish     = '0;
        wr_burst_data     = '0;
        if (w_active) begin
            req_wr_data_req[r_grant]   = wr_burst_data_req;
            req_rd_data_valid[r_grant] = rd_burst_data_valid;
            wr_burst_data              = req_wr_data[r_grant*MEM_DATA_BITS +: MEM_DATA_BITS];
        end else begin
            wr_burst_data = '0;
        end
        if (r_state == ST_WAIT) begin
            if (r_op_rd) begin
                req_rd_finish[r_grant] = rd_burst_finish;
            end else begin
                req_wr_finish[r_grant] = wr_burst_finish;
            end
        end else begin
            req_rd_finish = '0;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] r_to_cnt;
    logic        r_timeout;

    // Watchdog: counts WAIT cycles of the current burst; the flag is sticky until reset.
    always_ff @(posedge mem_clk) begin
        if (!rst_n) begin
            r_to_cnt  <= 16'd0;
            r_timeout <= 1'b0;
        end else if (r_state == ST_ISSUE) begin
            r_to_cnt <= 16'd0;
        end else if (r_state == ST_WAIT) begin
            if (r_to_cnt != 16'hFFFF) begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end else begin
                r_to_cnt <= r_to_cnt;
            end
            if ((r_to_cnt + 16'd1) >= TO_LIMIT) begin
                r_timeout <= 1'b1;
            end else begin
                r_timeout <= r_timeout;
            end
        end else begin
            r_to_cnt <= r_to_cnt;
        end
    end

    assign arb_timeout = r_timeout;
`endif

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Directed bench for mem_burst_arbiter: a table of arbitration steps plus reset and watchdog sequences.
// The bench plays both the requesters and the burst engine.
module tb_mem_burst_arbiter;

    logic         clk;
    logic         rst_n;
    logic [1:0]   req_rd_req, req_wr_req;
    logic [19:0]  req_rd_len, req_wr_len;
    logic [47:0]  req_rd_addr, req_wr_addr;
    logic [127:0] req_wr_data;
    logic [1:0]   req_wr_data_req, req_rd_data_valid, req_rd_finish, req_wr_finish;
    logic [63:0]  req_rd_data;
    logic         rd_burst_req, wr_burst_req;
    logic [9:0]   rd_burst_len, wr_burst_len;
    logic [23:0]  rd_burst_addr, wr_burst_addr;
    logic [63:0]  wr_burst_data;
    logic         wr_burst_data_req, rd_burst_data_valid, rd_burst_finish, wr_burst_finish;
    logic [63:0]  rd_burst_data;
    logic [0:0]   grant_id;
    logic         busy;
`ifdef ARB_TIMEOUT_EN
    logic         arb_timeout;
`endif

    mem_burst_arbiter #(
        .NUM_PORTS(2), .MEM_DATA_BITS(64), .ADDR_BITS(24), .TIMEOUT_CYCLES(16)
    ) dut (
        .mem_clk(clk), .rst_n(rst_n),
        .req_rd_req(req_rd_req), .req_wr_req(req_wr_req),
        .req_rd_len(req_rd_len), .req_wr_len(req_wr_len),
        .req_rd_addr(req_rd_addr), .req_wr_addr(req_wr_addr),
        .req_wr_data(req_wr_data), .req_wr_data_req(req_wr_data_req),
        .req_rd_data(req_rd_data), .req_rd_data_valid(req_rd_data_valid),
        .req_rd_finish(req_rd_finish), .req_wr_finish(req_wr_finish),
        .rd_burst_req(rd_burst_req), .wr_burst_req(wr_burst_req),
        .rd_burst_len(rd_burst_len), .wr_burst_len(wr_burst_len),
        .rd_burst_addr(rd_burst_addr), .wr_burst_addr(wr_burst_addr),
        .wr_burst_data(wr_burst_data), .wr_burst_data_req(wr_burst_data_req),
        .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_finish(rd_burst_finish),
        .wr_burst_finish(wr_burst_finish), .rd_burst_data(rd_burst_data),
        .grant_id(grant_id), .busy(busy)
`ifdef ARB_TIMEOUT_EN
        , .arb_timeout(arb_timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [9:0]  rd_len_t [2] = '{10'd4, 10'd2};
    logic [9:0]  wr_len_t [2] = '{10'd3, 10'd8};
    logic [23:0] rd_addr_t[2] = '{24'h000100, 24'h001100};
    logic [23:0] wr_addr_t[2] = '{24'h000200, 24'h001200};
    logic [63:0] wdata_t  [2] = '{64'hAAAA_0000_1111_2222, 64'h5555_3333_4444_6666};

    typedef struct {
        bit       rst;
        logic [1:0] rd;
        logic [1:0] wr;
        int       port;
        bit       rd_op;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_issue();
        bit seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            seen = rd_burst_req | wr_burst_req;
        end
        if (!seen) check("issue_timeout", 64'd0, 64'd1);
    endtask

    // One full burst as both requester and engine, checking command, routing and finish.
    task automatic run_burst(input int p, input bit rd);
        int       len;
        logic [1:0] own;
        own = 2'b01 << p;
        len = rd ? int'(rd_len_t[p]) : int'(wr_len_t[p]);
        wait_issue();
        check("grant_id", 64'(grant_id), 64'(p));
        check("busy_issue", 64'(busy), 64'd1);
        check("engine_req", {62'd0, rd_burst_req, wr_burst_req}, rd ? 64'd2 : 64'd1);
        if (rd) begin
            check("rd_len", 64'(rd_burst_len), 64'(rd_len_t[p]));
            check("rd_addr", 64'(rd_burst_addr), 64'(rd_addr_t[p]));
        end else begin
            check("wr_len", 64'(wr_burst_len), 64'(wr_len_t[p]));
            check("wr_addr", 64'(wr_burst_addr), 64'(wr_addr_t[p]));
        end
        tick();
        check("engine_req_wait", {62'd0, rd_burst_req, wr_burst_req}, 64'd0);
        if (rd) wr_burst_finish = 1'b1; else rd_burst_finish = 1'b1;
        #1;
        check("wrong_finish", {60'd0, req_rd_finish, req_wr_finish}, 64'd0);
        tick();
        wr_burst_finish = 1'b0;
        rd_burst_finish = 1'b0;
        for (int b = 0; b < len; b++) begin
            if (rd) begin
                rd_burst_data_valid = 1'b1;
                rd_burst_data = {32'hD0D0_0000, 32'(b)};
                #1;
                check("rd_valid", 64'(req_rd_data_valid), 64'(own));
                check("rd_data", req_rd_data, {32'hD0D0_0000, 32'(b)});
            end else begin
                wr_burst_data_req = 1'b1;
                #1;
                check("wr_data_req", 64'(req_wr_data_req), 64'(own));
                check("wr_data", wr_burst_data, wdata_t[p]);
            end
            tick();
            rd_burst_data_valid = 1'b0;
            wr_burst_data_req = 1'b0;
        end
        if (rd) begin
            rd_burst_finish = 1'b1;
            req_rd_req[p] = 1'b0;
        end else begin
            wr_burst_finish = 1'b1;
            req_wr_req[p] = 1'b0;
        end
        #1;
        check("finish", {60'd0, req_rd_finish, req_wr_finish}, rd ? 64'(own) << 2 : 64'(own));
        tick();
        rd_burst_finish = 1'b0;
        wr_burst_finish = 1'b0;
        #1;
        check("cool_busy", {61'd0, busy, req_rd_finish | req_wr_finish}, 64'd4);
        tick();
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b1, 2'b01, 2'b00, 0, 1'b1};
        vecs[1]  = '{1'b1, 2'b11, 2'b00, 0, 1'b1};
        vecs[2]  = '{1'b0, 2'b00, 2'b00, 1, 1'b1};
        vecs[3]  = '{1'b0, 2'b11, 2'b00, 0, 1'b1};
        vecs[4]  = '{1'b0, 2'b00, 2'b00, 1, 1'b1};
        vecs[5]  = '{1'b0, 2'b11, 2'b00, 0, 1'b1};
        vecs[6]  = '{1'b0, 2'b00, 2'b00, 1, 1'b1};
        vecs[7]  = '{1'b0, 2'b10, 2'b10, 1, 1'b1};
        vecs[8]  = '{1'b0, 2'b00, 2'b00, 1, 1'b0};
        vecs[9]  = '{1'b0, 2'b00, 2'b01, 0, 1'b0};
        vecs[10] = '{1'b0, 2'b01, 2'b10, 1, 1'b0};
        vecs[11] = '{1'b0, 2'b00, 2'b00, 0, 1'b1};

        rst_n = 1'b0;
        req_rd_req = 2'b00;
        req_wr_req = 2'b00;
        req_rd_len  = {rd_len_t[1], rd_len_t[0]};
        req_wr_len  = {wr_len_t[1], wr_len_t[0]};
        req_rd_addr = {rd_addr_t[1], rd_addr_t[0]};
        req_wr_addr = {wr_addr_t[1], wr_addr_t[0]};
        req_wr_data = {wdata_t[1], wdata_t[0]};
        wr_burst_data_req = 1'b0;
        rd_burst_data_valid = 1'b0;
        rd_burst_finish = 1'b0;
        wr_burst_finish = 1'b0;
        rd_burst_data = 64'd0;
        tick();
        tick();
        check("rst_busy_grant", {62'd0, busy, grant_id}, 64'd0);
        check("rst_reqs", {62'd0, rd_burst_req, wr_burst_req}, 64'd0);
        check("rst_lens", {44'd0, rd_burst_len, wr_burst_len}, 64'd0);
        check("rst_addrs", {16'd0, rd_burst_addr, wr_burst_addr}, 64'd0);
        check("rst_strobes", {56'd0, req_wr_data_req, req_rd_data_valid, req_rd_finish, req_wr_finish}, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].rst) begin
                req_rd_req = 2'b00;
                req_wr_req = 2'b00;
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            req_rd_req = req_rd_req | vecs[i].rd;
            req_wr_req = req_wr_req | vecs[i].wr;
            run_burst(vecs[i].port, vecs[i].rd_op);
        end

        // Reset in the middle of a port0 burst; rr_ptr had moved to 1, so port0 must win again.
        req_rd_req = 2'b01;
        wait_issue();
        check("mid_grant", 64'(grant_id), 64'd0);
        tick();
        rd_burst_data_valid = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_busy_grant", {62'd0, busy, grant_id}, 64'd0);
        check("mid_rst_cmd", {26'd0, rd_burst_req, rd_burst_len, rd_burst_addr}, 64'd0);
        check("mid_rst_valid", 64'(req_rd_data_valid), 64'd0);
        rd_burst_data_valid = 1'b0;
        req_rd_req = 2'b11;
        run_burst(0, 1'b1);
        run_burst(1, 1'b1);

`ifdef ARB_TIMEOUT_EN
        req_rd_req = 2'b01;
        wait_issue();
        for (int c = 0; c < 16; c++) tick();
        check("timeout_before", 64'(arb_timeout), 64'd0);
        tick();
        check("timeout_set", 64'(arb_timeout), 64'd1);
        for (int c = 0; c < 5; c++) tick();
        check("timeout_sticky", {62'd0, arb_timeout, busy}, 64'd3);
        req_rd_req = 2'b00;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("timeout_rst", {62'd0, arb_timeout, busy}, 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
